// File: rtl/fir_xifu_issue_queue.sv
// fir_xifu_issue_queue
// Entry stage of the FIR XIFU. It sits directly upstream of the ID stage.
// It terminates the XIF issue and commit handshakes and decides accept/reject
// from the custom-0 opcode. Accepted instructions and their operands are held
// in an in-order queue. The head entry is released to ID only once the core
// has committed it. Killed entries are dropped without producing any output.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous flush of every entry
//   issue_*             XIF issue request (valid/ready/accept, instr, id, rs1/rs2)
//   commit_*            XIF commit strobe with id and kill flag
//   id_*                head entry toward ID (valid/ready, instr, id, rs1, rs2)
//   count_o             number of occupied entries
module fir_xifu_issue_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned X_ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE     = 7'h0B
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [31:0]             issue_instr_i,
    input  logic [X_ID_WIDTH-1:0]   issue_id_i,
    input  logic [31:0]             issue_rs1_i,
    input  logic [31:0]             issue_rs2_i,
    input  logic [1:0]              issue_rs_valid_i,
    output logic                    issue_accept_o,
    input  logic                    commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]   commit_id_i,
    input  logic                    commit_kill_i,
    output logic                    id_valid_o,
    input  logic                    id_ready_i,
    output logic [31:0]             id_instr_o,
    output logic [X_ID_WIDTH-1:0]   id_id_o,
    output logic [31:0]             id_rs1_o,
    output logic [31:0]             id_rs2_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0]           instr;
        logic [X_ID_WIDTH-1:0] id;
        logic [31:0]           rs1;
        logic [31:0]           rs2;
    } entry_t;

    typedef enum logic [1:0] {
        HEAD_IDLE,
        HEAD_DROP,
        HEAD_SEND,
        HEAD_WAIT
    } head_state_e;

    logic [DEPTH-1:0] r_valid;
    logic [DEPTH-1:0] r_committed;
    logic [DEPTH-1:0] r_killed;
    entry_t           r_entry [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_match;
    logic             w_full;
    logic             w_ops_ok;
    logic             w_push;
    logic             w_pop;
    logic             w_new_hit;
    logic [DEPTH-1:0] w_cam_hit;
    head_state_e      w_head_state;

    // Issue-side decode and handshake
    always_comb begin
        w_match  = (issue_instr_i[6:0] == OPCODE);
        w_full   = (r_count == CNT_W'(DEPTH));
        w_ops_ok = (issue_rs_valid_i == 2'b11);
        w_push   = issue_valid_i & w_match & ~w_full & w_ops_ok;
    end

    assign issue_ready_o  = ~w_match | (~w_full & w_ops_ok);
    assign issue_accept_o = issue_valid_i & w_match;

    // Commit CAM over stored entries that are still awaiting a verdict
    always_comb begin
        w_cam_hit = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_cam_hit[i] = commit_valid_i & r_valid[i] & ~r_committed[i]
                         & ~r_killed[i] & (r_entry[i].id == commit_id_i);
        end
        // A commit for the instruction being pushed this cycle lands on the new entry
        w_new_hit = commit_valid_i & w_push & (commit_id_i == issue_id_i);
    end

    // Head state decode: the state is fully carried by the head entry flags
    always_comb begin
        w_head_state = HEAD_IDLE;
        id_valid_o   = 1'b0;
        w_pop        = 1'b0;
        if (r_valid[r_rd_ptr]) begin
            if (r_killed[r_rd_ptr]) begin
                w_head_state = HEAD_DROP;
            end else if (r_committed[r_rd_ptr]) begin
                w_head_state = HEAD_SEND;
            end else begin
                w_head_state = HEAD_WAIT;
            end
        end
        case (w_head_state)
            HEAD_DROP: w_pop = 1'b1;
            HEAD_SEND: begin
                id_valid_o = 1'b1;
                w_pop      = id_ready_i;
            end
            default: ;
        endcase
    end

    // Control state: flags, pointers, occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_killed    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else if (clear_i) begin
            r_valid     <= '0;
            r_committed <= '0;
            r_killed    <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_cam_hit[i]) begin
                    if (commit_kill_i) begin
                        r_killed[i] <= 1'b1;
                    end else begin
                        r_committed[i] <= 1'b1;
                    end
                end
            end
            // Push slot is always free, so it never collides with a CAM hit or the pop slot
            if (w_push) begin
                r_valid[r_wr_ptr]     <= 1'b1;
                r_committed[r_wr_ptr] <= w_new_hit & ~commit_kill_i;
                r_killed[r_wr_ptr]    <= w_new_hit & commit_kill_i;
                r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_valid[r_rd_ptr]     <= 1'b0;
                r_committed[r_rd_ptr] <= 1'b0;
                r_killed[r_rd_ptr]    <= 1'b0;
                r_rd_ptr              <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; contents are qualified by r_valid so no reset is needed
    always_ff @(posedge clk_i) begin
        if (w_push && !clear_i) begin
            r_entry[r_wr_ptr] <= '{instr: issue_instr_i, id: issue_id_i,
                                   rs1: issue_rs1_i, rs2: issue_rs2_i};
        end
    end

    assign id_instr_o = r_entry[r_rd_ptr].instr;
    assign id_id_o    = r_entry[r_rd_ptr].id;
    assign id_rs1_o   = r_entry[r_rd_ptr].rs1;
    assign id_rs2_o   = r_entry[r_rd_ptr].rs2;
    assign count_o    = r_count;

endmodule

// File: tb/tb_fir_xifu_issue_queue.sv
// Bench for fir_xifu_issue_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_fir_xifu_issue_queue;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clear_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [3:0]  issue_id_i;
    logic [31:0] issue_rs1_i;
    logic [31:0] issue_rs2_i;
    logic [1:0]  issue_rs_valid_i;
    logic        issue_accept_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_instr_o;
    logic [3:0]  id_id_o;
    logic [31:0] id_rs1_o;
    logic [31:0] id_rs2_o;
    logic [2:0]  count_o;

    fir_xifu_issue_queue #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .OPCODE(7'h0B)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
        .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rs_valid_i(issue_rs_valid_i), .issue_accept_o(issue_accept_o),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .commit_kill_i(commit_kill_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
        .id_instr_o(id_instr_o), .id_id_o(id_id_o),
        .id_rs1_o(id_rs1_o), .id_rs2_o(id_rs2_o), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  id;
        logic [31:0] rs1;
        logic [31:0] rs2;
        bit          committed;
        bit          killed;
    } ent_t;

    ent_t       q[$];
    logic [3:0] seen[$];
    int         n_errors = 0;
    int         n_checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected combinational view derived from the model and current inputs
    task automatic check_outputs();
        bit match;
        bit exp_ready;
        bit exp_valid;
        match     = (issue_instr_i[6:0] == 7'h0B);
        exp_ready = !match || (q.size() < DEPTH && issue_rs_valid_i == 2'b11);
        exp_valid = (q.size() > 0) && q[0].committed && !q[0].killed;
        chk("issue_ready", 64'(issue_ready_o), 64'(exp_ready));
        chk("issue_accept", 64'(issue_accept_o), 64'(issue_valid_i && match));
        chk("id_valid", 64'(id_valid_o), 64'(exp_valid));
        chk("count", 64'(count_o), 64'(q.size()));
        if (exp_valid) begin
            chk("id_instr", 64'(id_instr_o), 64'(q[0].instr));
            chk("id_id", 64'(id_id_o), 64'(q[0].id));
            chk("id_rs1", 64'(id_rs1_o), 64'(q[0].rs1));
            chk("id_rs2", 64'(id_rs2_o), 64'(q[0].rs2));
        end
    endtask

    // Reference behaviour for one clock edge
    task automatic model_step();
        bit   match;
        bit   push;
        bit   pop;
        ent_t e;
        if (!rst_ni || clear_i) begin
            q.delete();
            return;
        end
        match = (issue_instr_i[6:0] == 7'h0B);
        push  = issue_valid_i && match && q.size() < DEPTH && issue_rs_valid_i == 2'b11;
        pop   = 1'b0;
        if (q.size() > 0) pop = q[0].killed || (q[0].committed && id_ready_i);
        if (commit_valid_i) begin
            foreach (q[i]) begin
                if (!q[i].committed && !q[i].killed && q[i].id == commit_id_i) begin
                    if (commit_kill_i) q[i].killed = 1'b1;
                    else q[i].committed = 1'b1;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            e.instr     = issue_instr_i;
            e.id        = issue_id_i;
            e.rs1       = issue_rs1_i;
            e.rs2       = issue_rs2_i;
            e.committed = commit_valid_i && !commit_kill_i && commit_id_i == issue_id_i;
            e.killed    = commit_valid_i && commit_kill_i && commit_id_i == issue_id_i;
            q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(negedge clk_i);
        check_outputs();
        if (id_valid_o && id_ready_i) seen.push_back(id_id_o);
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic set_issue(input bit v, input logic [31:0] instr, input logic [3:0] id,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [1:0] rsv);
        issue_valid_i    = v;
        issue_instr_i    = instr;
        issue_id_i       = id;
        issue_rs1_i      = rs1;
        issue_rs2_i      = rs2;
        issue_rs_valid_i = rsv;
    endtask

    task automatic set_commit(input bit v, input logic [3:0] id, input bit kill);
        commit_valid_i = v;
        commit_id_i    = id;
        commit_kill_i  = kill;
    endtask

    task automatic idle();
        set_issue(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 2'b00);
        set_commit(1'b0, 4'h0, 1'b0);
        clear_i = 1'b0;
    endtask

    function automatic logic [3:0] free_id();
        logic [3:0] id;
        bit         used;
        for (int t = 0; t < 64; t++) begin
            id   = 4'($urandom_range(0, 15));
            used = 1'b0;
            foreach (q[i]) if (q[i].id == id) used = 1'b1;
            if (!used) return id;
        end
        return 4'hF;
    endfunction

    initial begin
        rst_ni     = 1'b0;
        id_ready_i = 1'b0;
        idle();
        q.delete();
        repeat (2) cyc();
        rst_ni = 1'b1;
        cyc();

        // Accepted instruction, committed the following cycle
        set_issue(1'b1, 32'h0000_000B, 4'd3, 32'hDEAD_BEEF, 32'h1234_5678, 2'b11);
        cyc();
        idle();
        set_commit(1'b1, 4'd3, 1'b0);
        cyc();
        set_commit(1'b0, 4'd0, 1'b0);
        id_ready_i = 1'b1;
        repeat (2) cyc();

        // Non-matching opcode completes without being stored
        set_issue(1'b1, 32'h0000_0033, 4'd7, 32'h1, 32'h2, 2'b11);
        cyc();
        idle();

        // Fill the queue, then a fifth matching issue sees ready low
        id_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_issue(1'b1, 32'h0000_100B | 32'(i << 12), 4'(i), 32'(i + 100), 32'(i + 200), 2'b11);
            cyc();
        end
        set_issue(1'b1, 32'h0000_000B, 4'd9, 32'h5, 32'h6, 2'b11);
        cyc();
        idle();
        set_commit(1'b1, 4'd0, 1'b0);
        id_ready_i = 1'b1;
        cyc();
        set_commit(1'b0, 4'd0, 1'b0);
        repeat (2) cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;

        // Ids 1,2,3 queued; 2 killed, 1 and 3 committed
        seen.delete();
        id_ready_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            set_issue(1'b1, 32'h0000_000B, 4'(i), 32'(i * 17), 32'(i * 33), 2'b11);
            cyc();
        end
        idle();
        set_commit(1'b1, 4'd2, 1'b1);
        cyc();
        set_commit(1'b1, 4'd1, 1'b0);
        cyc();
        set_commit(1'b1, 4'd3, 1'b0);
        cyc();
        set_commit(1'b0, 4'd0, 1'b0);
        id_ready_i = 1'b1;
        repeat (5) cyc();
        chk("kill_seq_len", 64'(seen.size()), 64'd2);
        if (seen.size() == 2) begin
            chk("kill_seq_first", 64'(seen[0]), 64'd1);
            chk("kill_seq_second", 64'(seen[1]), 64'd3);
        end

        // Commit in the push cycle
        id_ready_i = 1'b0;
        set_issue(1'b1, 32'hABCD_008B, 4'd5, 32'h55, 32'h66, 2'b11);
        set_commit(1'b1, 4'd5, 1'b0);
        cyc();
        idle();
        // Backpressure for 3 cycles, then flush
        repeat (3) cyc();
        clear_i = 1'b1;
        cyc();
        clear_i = 1'b0;
        repeat (2) cyc();

        // Reset in the middle of activity
        set_issue(1'b1, 32'h0000_000B, 4'd8, 32'h8, 32'h9, 2'b11);
        cyc();
        idle();
        rst_ni = 1'b0;
        q.delete();
        cyc();
        rst_ni = 1'b1;
        cyc();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] instr;
            instr = $urandom();
            instr[6:0] = ($urandom_range(0, 3) != 0) ? 7'h0B : 7'h33;
            set_issue($urandom_range(0, 9) < 6, instr, free_id(), $urandom(), $urandom(),
                      ($urandom_range(0, 4) != 0) ? 2'b11 : 2'($urandom_range(0, 3)));
            if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
                set_commit(1'b1, q[$urandom_range(0, q.size() - 1)].id, $urandom_range(0, 3) == 0);
            end else begin
                set_commit($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)),
                           $urandom_range(0, 3) == 0);
            end
            id_ready_i = ($urandom_range(0, 9) < 7);
            clear_i    = ($urandom_range(0, 49) == 0);
            cyc();
        end

        idle();
        cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
